// File: rtl/regfile_march_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_march_bist_ctrl_if
// Description : Control/status and register-file test-port bundle for the
//               March C- BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_march_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic                  done_o;
    logic                  pass_o;
    logic [ADDR_WIDTH-1:0] fail_addr_o;
    logic [2:0]            fail_elem_o;
    logic [DATA_WIDTH-1:0] fail_exp_o;
    logic [DATA_WIDTH-1:0] fail_act_o;
    logic [7:0]            fail_cnt_o;
    logic                  bist_o;
    logic                  csn_t_o;
    logic                  wen_t_o;
    logic [ADDR_WIDTH-1:0] a_t_o;
    logic [DATA_WIDTH-1:0] d_t_o;
    logic [DATA_WIDTH-1:0] q_t_i;

    // BIST controller side
    modport master (
        input  start_i, q_t_i,
        output done_o, pass_o, fail_addr_o, fail_elem_o, fail_exp_o,
               fail_act_o, fail_cnt_o, bist_o, csn_t_o, wen_t_o, a_t_o, d_t_o
    );

    // Test controller / register-file wrapper side
    modport slave (
        output start_i, q_t_i,
        input  done_o, pass_o, fail_addr_o, fail_elem_o, fail_exp_o,
               fail_act_o, fail_cnt_o, bist_o, csn_t_o, wen_t_o, a_t_o, d_t_o
    );
endinterface

`default_nettype wire

// File: rtl/regfile_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_march_bist_ctrl
// Description : March C- MBIST initiator for the register-file test port,
//               reporting pass/fail, first-fail details and a mismatch count.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_march_bist_ctrl #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 32,
    parameter int                    FIRST_ADDR = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_BG    = '0
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    regfile_march_bist_ctrl_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] c_first_addr = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SETUP = 4'd1,
        S_M0    = 4'd2,
        S_M1    = 4'd3,
        S_M2    = 4'd4,
        S_M3    = 4'd5,
        S_M4    = 4'd6,
        S_M5    = 4'd7,
        S_DRAIN = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  r_phase;      // 0: read slot, 1: write slot of a read-write element
    logic                  w_phase_nxt;
    logic                  w_start_acc;

    logic                  w_march;
    logic                  w_up;
    logic                  w_rw;
    logic [2:0]            w_elem;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rexp;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_mismatch;

    logic                  r_cmp_vld;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [2:0]            r_cmp_elem;

    logic                  r_done;
    logic                  r_pass;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_elem;
    logic [DATA_WIDTH-1:0] r_fail_exp;
    logic [DATA_WIDTH-1:0] r_fail_act;
    logic [7:0]            r_fail_cnt;

    // Element decode: direction, op mix and data polarity of the current element
    always_comb begin
        w_march = 1'b1;
        w_up    = 1'b1;
        w_rw    = 1'b0;
        w_elem  = 3'd0;
        w_wdata = DATA_BG;
        w_rexp  = DATA_BG;
        case (r_state)
            S_M0: w_elem = 3'd0;
            S_M1: begin w_elem = 3'd1; w_rw = 1'b1; w_wdata = ~DATA_BG; end
            S_M2: begin w_elem = 3'd2; w_rw = 1'b1; w_rexp  = ~DATA_BG; end
            S_M3: begin w_elem = 3'd3; w_rw = 1'b1; w_up = 1'b0; w_wdata = ~DATA_BG; end
            S_M4: begin w_elem = 3'd4; w_rw = 1'b1; w_up = 1'b0; w_rexp  = ~DATA_BG; end
            S_M5: w_elem = 3'd5;
            default: w_march = 1'b0;
        endcase
    end

    assign w_rd = w_march && ((r_state == S_M5) || (w_rw && !r_phase));
    assign w_wr = w_march && !w_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    w_state_nxt = S_SETUP;
                    w_start_acc = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_M0;
                w_addr_nxt  = c_first_addr;
                w_phase_nxt = 1'b0;
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (w_rw && !r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    // Terminal address ends the element; the next one starts at its own end
                    if (r_addr == (w_up ? c_last_addr : c_first_addr)) begin
                        case (r_state)
                            S_M0:    begin w_state_nxt = S_M1;    w_addr_nxt = c_first_addr; end
                            S_M1:    begin w_state_nxt = S_M2;    w_addr_nxt = c_first_addr; end
                            S_M2:    begin w_state_nxt = S_M3;    w_addr_nxt = c_last_addr;  end
                            S_M3:    begin w_state_nxt = S_M4;    w_addr_nxt = c_last_addr;  end
                            S_M4:    begin w_state_nxt = S_M5;    w_addr_nxt = c_first_addr; end
                            default: begin w_state_nxt = S_DRAIN; w_addr_nxt = '0;           end
                        endcase
                    end else begin
                        w_addr_nxt = w_up ? (r_addr + 1'b1) : (r_addr - 1'b1);
                    end
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_mismatch = r_cmp_vld && (bus.q_t_i != r_cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_vld   <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_cmp_vld <= w_rd;
            if (w_rd) begin
                r_cmp_exp  <= w_rexp;
                r_cmp_addr <= r_addr;
                r_cmp_elem <= w_elem;
            end
            if (w_start_acc) begin
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= '0;
                r_fail_exp  <= '0;
                r_fail_act  <= '0;
                r_fail_cnt  <= '0;
            end else begin
                if (w_mismatch) begin
                    if (r_fail_cnt != 8'hFF) begin
                        r_fail_cnt <= r_fail_cnt + 8'd1;
                    end
                    if (r_fail_cnt == 8'd0) begin
                        r_fail_addr <= r_cmp_addr;
                        r_fail_elem <= r_cmp_elem;
                        r_fail_exp  <= r_cmp_exp;
                        r_fail_act  <= bus.q_t_i;
                    end
                end
                // The last M5 compare resolves in DRAIN, so fold it into pass
                if (r_state == S_DRAIN) begin
                    r_done <= 1'b1;
                    r_pass <= (r_fail_cnt == 8'd0) && !w_mismatch;
                end
            end
        end
    end

    assign bus.bist_o      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.csn_t_o     = !w_march;
    assign bus.wen_t_o     = !w_wr;
    assign bus.a_t_o       = w_march ? r_addr : '0;
    assign bus.d_t_o       = w_wr ? w_wdata : '0;
    assign bus.done_o      = r_done;
    assign bus.pass_o      = r_pass;
    assign bus.fail_addr_o = r_fail_addr;
    assign bus.fail_elem_o = r_fail_elem;
    assign bus.fail_exp_o  = r_fail_exp;
    assign bus.fail_act_o  = r_fail_act;
    assign bus.fail_cnt_o  = r_fail_cnt;

endmodule

`default_nettype wire
